// File: rtl/pll_reset_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding,
// default timing parameters and small arithmetic helpers.
package pll_reset_pkg;

    // Default timing, in cycles of the free-running reference clock.
    localparam int unsigned DEF_PLL_RESET_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_SOFT_RESET_CYCLES   = 32;

    // Sequencer states. PLL_RST is the reset/restart state.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT_RST  = 3'd4
    } seq_state_t;

    // Larger of two cycle counts, used to size the shared counter.
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Increment an 8-bit event count, sticking at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both stages clear to RESET_VAL on the synchronous reset.
module bit_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] stage_q;
    logic [1:0] stage_d;

    // Shift the raw input one stage further down the chain each cycle.
    always_comb begin
        stage_d = {stage_q[0], d_i};
    end

    // Synchronizer register chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= {2{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up / recovery sequencer for a PLL and the system it clocks.
// Holds the PLL in reset, waits for a lock that stays stable, then
// releases the system reset. Lock loss restarts the PLL; a soft reset
// request re-asserts only the system reset. All timing runs off the
// board reference clock, never the PLL output.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned SOFT_RESET_CYCLES   = DEF_SOFT_RESET_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_areset,
    output logic       sys_reset,
    input  logic       soft_reset_req,
    output logic       soft_reset_ack,
    output logic [7:0] lock_lost_count,
    output logic       timeout_err
);

    // One counter is shared by every timed state, so it is sized for the
    // longest interval any of them needs.
    localparam int unsigned CNT_MAX = max2(max2(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES),
                                           max2(LOCK_TIMEOUT_CYCLES, SOFT_RESET_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal counts: a state that must last N cycles leaves when the
    // counter reads N-1 (the counter starts at 0 on state entry).
    localparam cnt_t PLL_LAST    = cnt_t'(PLL_RESET_CYCLES - 1);
    localparam cnt_t STABLE_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t TMO_LAST    = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t SOFT_LAST   = cnt_t'(SOFT_RESET_CYCLES - 1);
    localparam cnt_t CNT_TOP     = cnt_t'(CNT_MAX);

    seq_state_t state_q;
    seq_state_t state_d;
    cnt_t       cnt_q;
    cnt_t       cnt_d;
    logic       pending_q;
    logic       pending_d;
    logic [7:0] lost_q;
    logic [7:0] lost_d;
    logic       timeout_err_q;
    logic       timeout_err_d;
    logic       pll_areset_q;
    logic       pll_areset_d;
    logic       sys_reset_q;
    logic       sys_reset_d;
    logic       soft_reset_ack_q;
    logic       soft_reset_ack_d;

    logic       locked_s;
    logic       req_any_s;
    logic       entering_run_s;

    // pll_locked comes from the PLL's own domain; only the synchronized
    // copy is ever used for decisions.
    bit_sync #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    // Next-state decision, lock-loss counting and timeout flagging.
    always_comb begin
        state_d       = state_q;
        lost_d        = lost_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = ST_PLL_RST;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a coincident soft reset request; the
                // request is kept pending by the pending-flag logic.
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    lost_d  = sat_inc8(lost_q);
                end else if (soft_reset_req) begin
                    state_d = ST_SOFT_RST;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SOFT_RST: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    lost_d  = sat_inc8(lost_q);
                end else if (cnt_q == SOFT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SOFT_RST;
                end
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // Shared counter, soft-reset bookkeeping and Moore output decode.
    always_comb begin
        // Counter restarts on every state change and sticks at its top
        // value rather than wrapping (it only idles there in RUN).
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_TOP) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Any request, in any state, lands in the pending flag (further
        // requests coalesce). Leaving RUN for SOFT_RST or PLL_RST keeps it
        // set; the next entry to RUN acknowledges it once, because the
        // system has just been through reset either way.
        req_any_s      = pending_q | soft_reset_req;
        entering_run_s = (state_d == ST_RUN) && (state_q != ST_RUN);
        if (entering_run_s) begin
            pending_d        = 1'b0;
            soft_reset_ack_d = req_any_s;
        end else begin
            pending_d        = req_any_s;
            soft_reset_ack_d = 1'b0;
        end

        pll_areset_d = (state_d == ST_PLL_RST);
        sys_reset_d  = (state_d != ST_RUN);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_PLL_RST;
            cnt_q            <= '0;
            pending_q        <= 1'b0;
            lost_q           <= 8'd0;
            timeout_err_q    <= 1'b0;
            pll_areset_q     <= 1'b1;
            sys_reset_q      <= 1'b1;
            soft_reset_ack_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pending_q        <= pending_d;
            lost_q           <= lost_d;
            timeout_err_q    <= timeout_err_d;
            pll_areset_q     <= pll_areset_d;
            sys_reset_q      <= sys_reset_d;
            soft_reset_ack_q <= soft_reset_ack_d;
        end
    end

    assign pll_areset      = pll_areset_q;
    assign sys_reset       = sys_reset_q;
    assign soft_reset_ack  = soft_reset_ack_q;
    assign lock_lost_count = lost_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized
// lock/request stimulus, checked every cycle against a phase/timestamp
// reference model.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int SRC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_areset;
    logic       sys_reset;
    logic       soft_reset_ack;
    logic [7:0] lock_lost_count;
    logic       timeout_err;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .SOFT_RESET_CYCLES   (SRC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .pll_areset      (pll_areset),
        .sys_reset       (sys_reset),
        .soft_reset_req  (soft_reset_req),
        .soft_reset_ack  (soft_reset_ack),
        .lock_lost_count (lock_lost_count),
        .timeout_err     (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase plus the cycle number it was entered at; durations come from
    // elapsed time rather than a counter. Lock seen by the sequencer is
    // the pll_locked sample from two edges earlier.
    localparam int P_PLL = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_SOFT = 4;
    int   m_cyc = 0;
    int   m_ph  = P_PLL;
    int   m_ent = 0;
    bit   m_pend = 1'b0;
    int   m_lost = 0;
    bit   m_terr = 1'b0;
    bit   m_ack  = 1'b0;
    bit   m_hist[$];

    function automatic void model_step(input bit r, input bit l, input bit q);
        bit ls;
        bit any;
        int el;
        int nph;
        m_cyc++;
        if (r) begin
            m_ph = P_PLL; m_ent = m_cyc; m_pend = 1'b0;
            m_lost = 0; m_terr = 1'b0; m_ack = 1'b0;
            m_hist.delete();
            return;
        end
        ls = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
        m_hist.push_back(l);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        el  = m_cyc - m_ent;
        nph = m_ph;
        case (m_ph)
            P_PLL:  if (el == PRC) nph = P_WAIT;
            P_WAIT: if (ls) nph = P_STAB;
                    else if (el == LTC) begin nph = P_PLL; m_terr = 1'b1; end
            P_STAB: if (!ls) nph = P_WAIT;
                    else if (el == LSC) nph = P_RUN;
            P_RUN:  if (!ls) begin nph = P_PLL; if (m_lost < 255) m_lost++; end
                    else if (q) nph = P_SOFT;
            P_SOFT: if (!ls) begin nph = P_PLL; if (m_lost < 255) m_lost++; end
                    else if (el == SRC) nph = P_RUN;
            default: nph = P_PLL;
        endcase
        any = m_pend | q;
        if (nph == P_RUN && m_ph != P_RUN) begin
            m_ack = any; m_pend = 1'b0;
        end else begin
            m_ack = 1'b0; m_pend = any;
        end
        if (nph != m_ph) begin
            m_ph = nph; m_ent = m_cyc;
        end
    endfunction

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic tick(input bit r, input bit l, input bit q);
        rst = r; pll_locked = l; soft_reset_req = q;
        @(posedge clk);
        model_step(r, l, q);
        #1;
        check_eq("m_pll_areset", pll_areset, (m_ph == P_PLL));
        check_eq("m_sys_reset", sys_reset, (m_ph != P_RUN));
        check_eq("m_ack", soft_reset_ack, m_ack);
        check_eq("m_lost", lock_lost_count, m_lost);
        check_eq("m_timeout", timeout_err, m_terr);
    endtask

    // Hold lock until the system is released, counting cycles and acks.
    task automatic lock_until_run(input int bound, output int n, output int acks);
        n = 0; acks = 0;
        while (sys_reset !== 1'b0 && n < bound) begin
            tick(1'b0, 1'b1, 1'b0);
            n++;
            if (soft_reset_ack === 1'b1) acks++;
        end
        if (sys_reset !== 1'b0) check_eq("run_bound", sys_reset, 32'd0);
    endtask

    // Stay in RUN for a while; count any system reset or ack seen.
    task automatic quiet_run(input int len, output int hi, output int acks);
        hi = 0; acks = 0;
        for (int i = 0; i < len; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (sys_reset === 1'b1) hi++;
            if (soft_reset_ack === 1'b1) acks++;
        end
    endtask

    initial begin
        int n, acks, hi, phi, lo_seen, hold, curl;
        rst = 1'b1; pll_locked = 1'b0; soft_reset_req = 1'b0;

        // Reset state.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("rst_pll_areset", pll_areset, 32'd1);
        check_eq("rst_sys_reset", sys_reset, 32'd1);
        check_eq("rst_ack", soft_reset_ack, 32'd0);
        check_eq("rst_lost", lock_lost_count, 32'd0);
        check_eq("rst_timeout", timeout_err, 32'd0);

        // Clean power-up: PLL reset width and release latency.
        n = 1;
        for (int i = 0; i < 20 && pll_areset === 1'b1; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (pll_areset === 1'b1) n++;
        end
        check_eq("pll_rst_len", n, PRC);
        lock_until_run(40, n, acks);
        check_eq("release_lat", n, 1 + LSC);
        check_eq("release_acks", acks, 32'd0);

        // Lock loss in RUN: 3-cycle reaction, count and saturation.
        tick(1'b0, 1'b0, 1'b0);
        check_eq("loss_lat1", pll_areset, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("loss_lat2", pll_areset, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("loss_lat3", pll_areset, 32'd1);
        check_eq("loss_count1", lock_lost_count, 32'd1);
        for (int k = 0; k < 299; k++) begin
            lock_until_run(60, n, acks);
            repeat (3) tick(1'b0, 1'b0, 1'b0);
        end
        check_eq("loss_sat", lock_lost_count, 32'd255);

        // Soft reset from RUN.
        lock_until_run(60, n, acks);
        tick(1'b0, 1'b1, 1'b1);
        hi = (sys_reset === 1'b1) ? 1 : 0;
        phi = 0; acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (sys_reset === 1'b1) hi++;
            if (pll_areset === 1'b1) phi++;
            if (soft_reset_ack === 1'b1) acks++;
        end
        check_eq("soft_sys_len", hi, SRC);
        check_eq("soft_acks", acks, 32'd1);
        check_eq("soft_no_pll", phi, 32'd0);

        // Lock never arrives: timeout, PLL retry, system held.
        tick(1'b1, 1'b0, 1'b0);
        n = 0; lo_seen = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
            if (sys_reset !== 1'b1) lo_seen++;
        end
        check_eq("timeout_lat", n, PRC + LTC);
        n = (pll_areset === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20 && pll_areset === 1'b1; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (pll_areset === 1'b1) n++;
            if (sys_reset !== 1'b1) lo_seen++;
        end
        check_eq("retry_pll_len", n, PRC);
        check_eq("timeout_sys_held", lo_seen, 32'd0);
        check_eq("timeout_sticky", timeout_err, 32'd1);

        // One-cycle lock glitch while STABLE delays release by a full window.
        tick(1'b1, 1'b1, 1'b0);
        n = 0;
        while (sys_reset !== 1'b0 && n < 60) begin
            n++;
            tick(1'b0, (n != 7), 1'b0);
        end
        check_eq("glitch_release", n, 18);

        // Request while waiting for lock: one ack on RUN entry, no SOFT_RST.
        tick(1'b1, 1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        lock_until_run(60, n, acks);
        quiet_run(10, hi, n);
        check_eq("wait_req_acks", acks + n, 32'd1);
        check_eq("wait_req_no_soft", hi, 32'd0);

        // Request coincident with lock loss in RUN.
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("coinc_pll_first", pll_areset, 32'd1);
        lock_until_run(60, n, acks);
        quiet_run(10, hi, n);
        check_eq("coinc_acks", acks + n, 32'd1);
        check_eq("coinc_no_soft", hi, 32'd0);

        // Randomized lock behaviour, requests and occasional resets.
        tick(1'b1, 1'b1, 1'b0);
        hold = 0; curl = 1;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                curl = ($urandom_range(0, 9) < 7) ? 1 : 0;
                hold = curl ? $urandom_range(1, 80) : $urandom_range(1, 45);
            end
            hold--;
            tick(($urandom_range(0, 799) == 0), curl[0], ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RESET_CYCLES, default 16: clk cycles pll_areset is held high per PLL reset.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before system reset releases.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before a PLL reset is retried.
REQ-004 SHALL have parameter SOFT_RESET_CYCLES, default 32: sys_reset hold length for a soft reset.
REQ-005 SHALL have port clk, input, 1: free-running board reference clock, not PLL-derived; the only clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock indication, asynchronous to clk.
REQ-008 SHALL have port pll_areset, output, 1: PLL reset, high = PLL held in reset.
REQ-009 SHALL have port sys_reset, output, 1: system reset request, high = system held in reset; consumers re-synchronize it into sys_clk.
REQ-010 SHALL have port soft_reset_req, input, 1: single-cycle request for a system reset without a PLL reset.
REQ-011 SHALL have port soft_reset_ack, output, 1: single-cycle completion pulse for a soft reset.
REQ-012 SHALL have port lock_lost_count, output, 8: saturating count of lock losses seen in RUN.
REQ-013 SHALL have port timeout_err, output, 1: sticky flag, set on any WAIT_LOCK timeout.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer to form locked_s; all decisions use locked_s only.
REQ-015 SHALL implement the registered states PLL_RST, WAIT_LOCK, STABLE, RUN and SOFT_RST, with Moore outputs decoded from the state register.
REQ-016 SHALL hold pll_areset=1 only in PLL_RST and hold sys_reset=0 only in RUN.
REQ-017 PLL_RST SHALL last exactly PLL_RESET_CYCLES cycles, then go to WAIT_LOCK with the shared cycle counter cleared.
REQ-018 WAIT_LOCK SHALL go to STABLE on the first cycle locked_s=1.
REQ-019 WAIT_LOCK SHALL go to PLL_RST and set timeout_err if LOCK_TIMEOUT_CYCLES cycles elapse without locked_s.
REQ-020 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles of locked_s=1.
REQ-021 STABLE SHALL return to WAIT_LOCK with the counter cleared and the timeout restarted on any locked_s=0.
REQ-022 RUN with locked_s=0 SHALL go to PLL_RST and increment lock_lost_count, saturating at 255.
REQ-023 Lock loss in RUN SHALL take priority over a coincident soft_reset_req; that request SHALL be latched as pending.
REQ-024 RUN with soft_reset_req=1 and locked_s=1 SHALL go to SOFT_RST.
REQ-025 SOFT_RST SHALL last SOFT_RESET_CYCLES cycles, then pulse soft_reset_ack for exactly one cycle on the RUN re-entry cycle.
REQ-026 locked_s=0 during SOFT_RST SHALL go to PLL_RST, increment lock_lost_count and keep the request pending.
REQ-027 soft_reset_req in any state other than RUN SHALL set a pending flag.
REQ-028 On entry to RUN with the pending flag set, the block SHALL pulse soft_reset_ack without a further reset, since the system reset has already occurred, and clear the flag.
REQ-029 soft_reset_req arriving while the pending flag is set SHALL coalesce into that pending request, giving one ack.
REQ-030 Each counter SHALL be sized from the larger of its parameters, SHALL clear on every state change, and SHALL NOT wrap.

Reset
REQ-031 rst SHALL force state PLL_RST, counter 0, pending 0, lock_lost_count 0, timeout_err 0 and synchronizer flops 0.
REQ-032 During rst, outputs SHALL be pll_areset=1, sys_reset=1, soft_reset_ack=0.
REQ-033 rst asserted mid-operation, in any state, SHALL restart the full sequence from PLL_RST.

Structure
REQ-034 The state enumeration and default parameter values SHALL live in a shared package, pll_reset_pkg.
REQ-035 The 2-flop synchronizer SHALL be a separate sub-module, bit_sync, reusable elsewhere in the codebase.

Verification
Test parameters: PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, SOFT_RESET_CYCLES=4.
REQ-036 Bench SHALL cover: pll_locked=1 from reset release -> pll_areset high exactly 4 cycles; sys_reset falls exactly 9 cycles after WAIT_LOCK entry (1 cycle to STABLE + 8 in STABLE).
REQ-037 Bench SHALL cover: pll_locked stuck 0 -> timeout_err set after 32 WAIT_LOCK cycles; pll_areset re-pulses for 4 cycles; sys_reset stays 1.
REQ-038 Bench SHALL cover: pll_locked glitching low for 1 cycle during STABLE -> return to WAIT_LOCK; sys_reset release delayed by a full 8 further stable cycles.
REQ-039 Bench SHALL cover: in RUN, drop pll_locked -> pll_areset rises 3 cycles later (2 sync + 1 state); lock_lost_count 0->1; 300 losses -> count saturates at 255.
REQ-040 Bench SHALL cover: in RUN, soft_reset_req pulse -> sys_reset high 4 cycles; single soft_reset_ack on RUN re-entry; pll_areset stays 0.
REQ-041 Bench SHALL cover: soft_reset_req in WAIT_LOCK, plus soft_reset_req coincident with lock loss in RUN -> exactly one ack each, on the next RUN entry, with no extra SOFT_RST.
